// File: rtl/sequential_sobel_xy.sv
// sequential_sobel_xy: per-column systolic Sobel element.
// Vertical smooth/diff per column, Gx/Gy across neighbours, selectable result.
module sequential_sobel_xy #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = DATA_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] current_in,
  input  logic [1:0]        mode,
  input  logic [OUT_W-1:0]  threshold,
  input  logic [DATA_W+1:0] left_smooth,
  input  logic [DATA_W+1:0] right_smooth,
  input  logic [DATA_W:0]   left_diff,
  input  logic [DATA_W:0]   right_diff,
  output logic [DATA_W+1:0] current_smooth,
  output logic [DATA_W:0]   current_diff,
  output logic              int_valid,
  output logic [OUT_W-1:0]  sobel_out,
  output logic              out_valid
);

  localparam int SW = DATA_W + 2;
  localparam int GW = DATA_W + 3;
  localparam int XW = (OUT_W > GW) ? OUT_W : GW;
  localparam logic [XW-1:0] MAXV =
    {XW{1'b1}} >> (XW - OUT_W);

  logic [DATA_W-1:0] p1, p2;
  logic [1:0]        rc;
  logic              warm;
  logic [SW-1:0]     smooth_n;
  logic [DATA_W:0]   diff_n;
  logic [GW-1:0]     gx, gy;
  logic [GW-1:0]     gx_n, gy_n;
  logic              g_valid;
  logic [SW-1:0]     ax, ay;
  logic [GW-1:0]     s;
  logic [XW-1:0]     sel;

  assign warm = in_valid & ~in_sof
              & (rc == 2'd2);

  assign smooth_n = SW'(current_in)
                  + {1'b0, p1, 1'b0}
                  + SW'(p2);
  assign diff_n = {1'b0, current_in}
                - {1'b0, p2};

  // smooth is unsigned, diff is two's complement
  assign gx_n = {1'b0, right_smooth}
              - {1'b0, left_smooth};
  assign gy_n =
      {{2{left_diff[DATA_W]}}, left_diff}
    + {current_diff[DATA_W], current_diff, 1'b0}
    + {{2{right_diff[DATA_W]}}, right_diff};

  assign ax = gx[GW-1] ? SW'(-gx) : SW'(gx);
  assign ay = gy[GW-1] ? SW'(-gy) : SW'(gy);
  assign s  = {1'b0, ax} + {1'b0, ay};

  always_comb begin
    sel = '0;
    unique case (mode)
      2'd0: sel = XW'(ax);
      2'd1: sel = XW'(ay);
      2'd2: sel = XW'(s);
      2'd3: sel = (XW'(s) >= XW'(threshold))
                ? MAXV : '0;
      default: sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1             <= '0;
      p2             <= '0;
      rc             <= '0;
      current_smooth <= '0;
      current_diff   <= '0;
      int_valid      <= 1'b0;
      gx             <= '0;
      gy             <= '0;
      g_valid        <= 1'b0;
      sobel_out      <= '0;
      out_valid      <= 1'b0;
    end else begin
      if (in_valid) begin
        p1             <= current_in;
        p2             <= p1;
        current_smooth <= smooth_n;
        current_diff   <= diff_n;
        if (in_sof)
          rc <= 2'd1;
        else if (rc != 2'd2)
          rc <= rc + 2'd1;
      end
      int_valid <= warm;
      if (int_valid) begin
        gx <= gx_n;
        gy <= gy_n;
      end
      g_valid <= int_valid;
      if (g_valid)
        sobel_out <= (sel > MAXV)
                   ? MAXV[OUT_W-1:0]
                   : sel[OUT_W-1:0];
      out_valid <= g_valid;
    end
  end

endmodule

// File: tb/tb_sequential_sobel_xy.sv
// tb_sequential_sobel_xy: directed + random frames vs a per-cycle model.
// Second instance with OUT_W=10 covers saturation.
module tb_sequential_sobel_xy;

  localparam int N = 2000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sof;
  logic [7:0]  current_in;
  logic [1:0]  mode;
  logic [10:0] threshold;
  logic [9:0]  thr10;
  logic [9:0]  left_smooth, right_smooth;
  logic [8:0]  left_diff, right_diff;
  logic [9:0]  current_smooth, cs2;
  logic [8:0]  current_diff, cd2;
  logic        int_valid, iv2;
  logic [10:0] sobel_out;
  logic [9:0]  so2;
  logic        out_valid, ov2;

  always #5 clk = ~clk;

  sequential_sobel_xy dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .current_in(current_in), .mode(mode),
    .threshold(threshold),
    .left_smooth(left_smooth),
    .right_smooth(right_smooth),
    .left_diff(left_diff),
    .right_diff(right_diff),
    .current_smooth(current_smooth),
    .current_diff(current_diff),
    .int_valid(int_valid),
    .sobel_out(sobel_out),
    .out_valid(out_valid)
  );

  sequential_sobel_xy #(.DATA_W(8), .OUT_W(10)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .current_in(current_in), .mode(mode),
    .threshold(thr10),
    .left_smooth(left_smooth),
    .right_smooth(right_smooth),
    .left_diff(left_diff),
    .right_diff(right_diff),
    .current_smooth(cs2),
    .current_diff(cd2),
    .int_valid(iv2),
    .sobel_out(so2),
    .out_valid(ov2)
  );

  bit a_rst[N+4], a_v[N+4], a_sof[N+4];
  int a_px[N+4], a_ls[N+4], a_rs[N+4];
  int a_ld[N+4], a_rd[N+4];
  int a_mode[N+4], a_thr[N+4];

  int e_sm[N+4], e_df[N+4], e_iv[N+4];
  int e_ov[N+4], e_o11[N+4], e_o10[N+4];
  bit s_v[N+4];
  int s_o11[N+4], s_o10[N+4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input int act,
                       input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  function automatic int pick(input int ax, input int ay,
                              input int m, input int thr,
                              input int maxv);
    int sum, r;
    sum = ax + ay;
    case (m)
      0: r = ax;
      1: r = ay;
      2: r = sum;
      default: r = (sum >= thr) ? maxv : 0;
    endcase
    return (r > maxv) ? maxv : r;
  endfunction

  task automatic put(input int c, input bit r,
                     input bit v, input bit sf,
                     input int px);
    a_rst[c] = r;
    a_v[c]   = v;
    a_sof[c] = sf;
    a_px[c]  = px;
  endtask

  // Pixel history per frame; results scheduled 3 cycles on.
  task automatic run_model();
    int p1, p2, cnt, gx, gy, ax, ay, m, t;
    bit warm;
    p1 = 0; p2 = 0; cnt = 0;
    e_sm[0] = 0; e_df[0] = 0; e_iv[0] = 0;
    e_ov[0] = 0; e_o11[0] = 0; e_o10[0] = 0;
    for (int c = 0; c < N - 1; c++) begin
      if (a_rst[c]) begin
        e_sm[c+1] = 0; e_df[c+1] = 0;
        e_iv[c+1] = 0; e_ov[c+1] = 0;
        e_o11[c+1] = 0; e_o10[c+1] = 0;
        s_v[c+2] = 0; s_v[c+3] = 0;
        p1 = 0; p2 = 0; cnt = 0;
        continue;
      end
      e_sm[c+1] = e_sm[c];
      e_df[c+1] = e_df[c];
      e_iv[c+1] = 0;
      if (a_v[c]) begin
        warm = !a_sof[c] && cnt >= 2;
        cnt = a_sof[c] ? 1 : (cnt < 2 ? cnt + 1 : 2);
        e_sm[c+1] = a_px[c] + 2 * p1 + p2;
        e_df[c+1] = a_px[c] - p2;
        e_iv[c+1] = warm ? 1 : 0;
        p2 = p1;
        p1 = a_px[c];
        if (warm) begin
          gx = a_rs[c+1] - a_ls[c+1];
          gy = a_ld[c+1] + 2 * e_df[c+1] + a_rd[c+1];
          ax = gx < 0 ? -gx : gx;
          ay = gy < 0 ? -gy : gy;
          m  = a_mode[c+2];
          t  = a_thr[c+2];
          s_v[c+3]   = 1;
          s_o11[c+3] = pick(ax, ay, m, t, 2047);
          s_o10[c+3] = pick(ax, ay, m, t % 1024, 1023);
        end
      end
      if (s_v[c+1]) begin
        e_ov[c+1]  = 1;
        e_o11[c+1] = s_o11[c+1];
        e_o10[c+1] = s_o10[c+1];
      end else begin
        e_ov[c+1]  = 0;
        e_o11[c+1] = e_o11[c];
        e_o10[c+1] = e_o10[c];
      end
    end
  endtask

  task automatic build();
    int m, t;
    for (int c = 0; c < N + 4; c++) begin
      put(c, 0, 0, 0, 0);
      a_ls[c] = 0; a_rs[c] = 0;
      a_ld[c] = 0; a_rd[c] = 0;
      a_mode[c] = 0; a_thr[c] = 0;
      s_v[c] = 0;
    end
    put(0, 1, 1, 0, 7);
    put(1, 1, 1, 0, 9);
    put(2, 0, 1, 1, 100);
    put(3, 0, 1, 0, 100);
    put(4, 0, 1, 0, 100);
    put(7, 0, 1, 0, 10);
    put(9, 0, 1, 0, 20);
    put(12, 0, 1, 0, 30);
    for (int c = 15; c <= 17; c++) put(c, 0, 1, 0, 50);
    a_rs[16] = 1020;
    a_ls[17] = 1020;
    a_ls[18] = 500; a_rs[18] = 500;
    for (int f = 0; f < 4; f++) begin
      put(21 + 3*f, 0, 1, 1, 0);
      put(22 + 3*f, 0, 1, 0, 0);
      put(23 + 3*f, 0, 1, 0, 255);
      a_ld[24 + 3*f] = 255; a_rd[24 + 3*f] = 255;
      a_rs[24 + 3*f] = 1020;
    end
    a_mode[25] = 1;
    a_mode[28] = 2;
    a_mode[31] = 3; a_thr[31] = 2000;
    a_mode[34] = 3; a_thr[34] = 2041;
    for (int c = 36; c <= 49; c++)
      put(c, 0, 1, (c == 36 || c == 43), 3 * c);
    put(50, 1, 1, 0, 200);
    put(51, 1, 1, 0, 201);
    for (int c = 52; c <= 54; c++) put(c, 0, 1, 0, c);
    m = 0; t = 0;
    for (int c = 60; c < N + 4; c++) begin
      if (c % 40 == 0) begin
        m = $urandom_range(0, 3);
        t = $urandom_range(0, 2047);
      end
      put(c, c < N && $urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 8,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 255));
      a_ls[c] = $urandom_range(0, 1020);
      a_rs[c] = $urandom_range(0, 1020);
      a_ld[c] = int'($urandom_range(0, 510)) - 255;
      a_rd[c] = int'($urandom_range(0, 510)) - 255;
      a_mode[c] = m;
      a_thr[c]  = t;
    end
  endtask

  task automatic drive(input int c);
    rst          = a_rst[c];
    in_valid     = a_v[c];
    in_sof       = a_sof[c];
    current_in   = 8'(a_px[c]);
    mode         = 2'(a_mode[c]);
    threshold    = 11'(a_thr[c]);
    thr10        = 10'(a_thr[c]);
    left_smooth  = 10'(a_ls[c]);
    right_smooth = 10'(a_rs[c]);
    left_diff    = 9'(a_ld[c]);
    right_diff   = 9'(a_rd[c]);
  endtask

  task automatic literal(input int c);
    case (c)
      5: begin
        check("warm_iv", int'(int_valid), 1);
        check("warm_smooth", int'(current_smooth), 400);
        check("warm_diff", int'($signed(current_diff)), 0);
      end
      4:  check("warm_iv_early", int'(int_valid), 0);
      13: begin
        check("gap_smooth", int'(current_smooth), 80);
        check("gap_diff", int'($signed(current_diff)), 20);
        check("gap_iv", int'(int_valid), 1);
      end
      14: check("gap_iv_once", int'(int_valid), 0);
      18: check("gx_pos", int'(sobel_out), 1020);
      19: check("gx_swap", int'(sobel_out), 1020);
      20: check("gx_equal", int'(sobel_out), 0);
      26: check("mode1_gy", int'(sobel_out), 1020);
      29: begin
        check("mode2_sum", int'(sobel_out), 2040);
        check("mode2_sat10", int'(so2), 1023);
      end
      32: check("mode3_hi", int'(sobel_out), 2047);
      35: check("mode3_lo", int'(sobel_out), 0);
      44: check("sof_iv0", int'(int_valid), 0);
      45: begin
        check("sof_iv1", int'(int_valid), 0);
        check("sof_inflight", int'(out_valid), 1);
      end
      46: check("sof_ov0", int'(out_valid), 0);
      47: check("sof_ov1", int'(out_valid), 0);
      48: check("sof_resume", int'(out_valid), 1);
      52: begin
        check("rst_smooth", int'(current_smooth), 0);
        check("rst_out", int'(sobel_out), 0);
        check("rst_ov", int'(out_valid), 0);
      end
      56: check("rst_ov_wait", int'(out_valid), 0);
      57: check("rst_ov_first", int'(out_valid), 1);
      default: ;
    endcase
  endtask

  initial begin
    build();
    run_model();
    for (int c = 0; c < N; c++) begin
      drive(c);
      @(negedge clk);
      if (c >= 1) begin
        check("int_valid", int'(int_valid), e_iv[c]);
        check("smooth", int'(current_smooth), e_sm[c]);
        check("diff", int'($signed(current_diff)), e_df[c]);
        check("out_valid", int'(out_valid), e_ov[c]);
        check("sobel_out", int'(sobel_out), e_o11[c]);
        check("int_valid10", int'(iv2), e_iv[c]);
        check("smooth10", int'(cs2), e_sm[c]);
        check("diff10", int'($signed(cd2)), e_df[c]);
        check("out_valid10", int'(ov2), e_ov[c]);
        check("sobel_out10", int'(so2), e_o10[c]);
        literal(c);
      end
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sequential_sobel_xy.md
# sequential_sobel_xy

Parametrised per-column systolic Sobel element, successor to the X-only column element. One instance per image column. All instances run in lockstep and exchange vertical intermediates with their left and right neighbours. Each instance computes Gx and Gy, plus a selectable output: |Gx|, |Gy|, |Gx|+|Gy|, or a thresholded binary edge. It adds valid/start-of-frame handling, warm-up suppression, and saturation.

## Interface
- DATA_W, 8, pixel width (unsigned)
- OUT_W, DATA_W+3, output width; results above 2^OUT_W-1 saturate
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  current_in valid this cycle; gaps allowed, no backpressure
- in_sof  in  1  qualifies first pixel (row 0) of a frame; ignored without in_valid
- current_in  in  DATA_W  pixel of this column, rows presented top to bottom
- mode  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=threshold
- threshold  in  OUT_W  compare value for mode 3
- left_smooth, right_smooth  in  DATA_W+2  neighbours' current_smooth
- left_diff, right_diff  in  DATA_W+1  neighbours' current_diff (two's complement)
- current_smooth  out  DATA_W+2  registered p[r]+2p[r-1]+p[r-2]
- current_diff  out  DATA_W+1  registered signed p[r]-p[r-2]
- int_valid  out  1  intermediates valid
- sobel_out  out  OUT_W  selected result
- out_valid  out  1  sobel_out valid

## Operation
- Shift regs p1 and p2 hold the last two accepted pixels.
  - They update only on in_valid: p1<=current_in, p2<=p1.
  - Gaps do not disturb them.
- Row counter rc: 2 bits, saturates at 2.
  - on in_valid&in_sof: rc<=1
  - else on in_valid: rc<=min(rc+1,2)
- The pixel is "warm" when its effective row index is ≥2, i.e. in_valid & !in_sof & rc==2.
- Stage 1, on every in_valid:
  - current_smooth <= current_in + 2·p1 + p2, unsigned, no overflow at DATA_W+2.
  - current_diff <= current_in − p2, signed DATA_W+1.
  - int_valid <= warm.
  - Non-valid cycles: int_valid<=0; intermediates hold.
- Stage 2, on int_valid:
  - gx <= right_smooth − left_smooth
  - gy <= left_diff + 2·current_diff + right_diff
  - Both are signed DATA_W+3, sign-extended before arithmetic.
  - g_valid <= int_valid.
- Stage 3, on g_valid:
  - ax=|gx| and ay=|gy| (DATA_W+2 unsigned). Two's-complement negate when negative; the most negative value cannot occur.
  - Sum s = ax+ay at DATA_W+3 bits.
  - Select by mode: ax, ay, s, or (s ≥ threshold ? all-ones : 0).
  - Saturate the selection to 2^OUT_W−1 if it exceeds OUT_W bits.
  - out_valid <= g_valid.
  - When not g_valid, out_valid<=0 and sobel_out holds.
- mode and threshold are sampled at stage 3. They must be held stable within a frame; a change affects the next result only.
- Neighbour inputs are valid only when the neighbour's int_valid is high, which is identical to the local int_valid in lockstep. Boundary columns tie the missing neighbour to 0, or to a replicated edge, at the integrator's choice.

## Timing
- Pixel accepted at edge of cycle t:
  - current_smooth/current_diff/int_valid visible in t+1
  - gx/gy in t+2
  - sobel_out/out_valid in t+3
- Latency is 3 cycles. Throughput is 1 pixel/cycle.
- First two pixels after in_sof (or after reset) produce no int_valid and no out_valid.
- in_sof on a pixel:
  - rc restarts immediately.
  - Results from the previous frame already in stages 2–3 still complete.
  - That pixel and the next accepted pixel give no int_valid.
- Reset mid-operation: the next cycle has all regs zero and rc=0; in-flight results are discarded.
- Reset values: current_smooth=0, current_diff=0, int_valid=0, sobel_out=0, out_valid=0, p1=p2=0, rc=0.
- rst has priority over in_valid on the same edge.

## Test plan
- **Reset:** rst high 2 cycles during in_valid traffic -> all outputs 0 the next cycle; no out_valid until 3 further valid pixels after release.
- **Warm-up/smoothing:** in_sof with pixel 100, then 100, 100 -> int_valid only on the third pixel (t+1), current_smooth=400, current_diff=0.
- **Gaps:** pixels 10, gap, 20, 2-cycle gap, 30 -> current_smooth=80, current_diff=20; int_valid one cycle only.
- **Gx edge:**
  - left_smooth=0, right_smooth=1020, mode 0 -> sobel_out=1020 at t+3.
  - Swapped -> 1020.
  - Equal values -> 0.
- **Gy and modes:**
  - Own column 0,0,255, neighbour diffs 255, Gx inputs 0/1020:
    - mode 1 -> 1020
    - mode 2 -> 2040
  - mode 3:
    - threshold 2000 -> 2047
    - threshold 2041 -> 0
  - OUT_W=10 with mode 2 -> 1023 (saturated).
- **Mid-stream in_sof:** in_sof after 5 warm pixels -> in-flight results still emitted; next two accepted pixels give no int_valid or out_valid.
